ram_access_ctrl: RTL and testbench

- Initiator-side controller for the team's single-port synchronous RAM (en/wr/address/data_in/data_out interface, registered read, data_out forced to 0 on any clock edge with en low).
- Accepts single or burst read/write commands over a valid/ready command channel.
- Streams write data in over a valid/ready channel and returns read data over a valid/ready response channel.
- Sits between a client (CPU stub/testbench sequencer) and one RAM instance; it drives the RAM pins directly.

---
 rtl/ram_access_ctrl_if.sv | 37 +++
 rtl/ram_access_ctrl.sv | 110 +++++++++++
 tb/tb_ram_access_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_access_ctrl_if.sv
// Client and RAM-side signal bundle for ram_access_ctrl.
// The controller uses the slave modport; the client/RAM environment uses master.
interface ram_access_ctrl_if #(
  parameter int AW = 3,
  parameter int DW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_len;
  logic          wd_valid;
  logic          wd_ready;
  logic [DW-1:0] wd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_last;
  logic          busy;
  logic          mem_en;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_len, wd_valid, wd_data, rsp_ready, mem_rdata,
    output cmd_ready, wd_ready, rsp_valid, rsp_data, rsp_last, busy,
           mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output cmd_valid, cmd_wr, cmd_addr, cmd_len, wd_valid, wd_data, rsp_ready, mem_rdata,
    input  cmd_ready, wd_ready, rsp_valid, rsp_data, rsp_last, busy,
           mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/ram_access_ctrl.sv
// Burst read/write controller driving a single-port synchronous RAM with registered read.
// Write beats become one-cycle RAM strobes; each read beat is issue, capture, then respond.
module ram_access_ctrl #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic             clk,
  input  logic             rst,
  ram_access_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_CAPT, RSP} state_e;

  localparam logic [AW-1:0] ONE = AW'(1);

  state_e        state_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] beats_q;
  logic [AW-1:0] addr_inc;
  logic          mem_en_q;
  logic          mem_wr_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          rsp_valid_q;
  logic [DW-1:0] rsp_data_q;
  logic          rsp_last_q;

  assign addr_inc      = addr_q + ONE;
  assign bus.cmd_ready = (state_q == IDLE) && !rst;
  assign bus.wd_ready  = (state_q == WR);
  assign bus.busy      = (state_q != IDLE) || mem_en_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_last  = rsp_last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      beats_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      // RAM strobes last exactly one cycle unless re-armed below
      mem_en_q <= 1'b0;
      mem_wr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            addr_q  <= bus.cmd_addr;
            beats_q <= bus.cmd_len;
            if (bus.cmd_wr) begin
              state_q <= WR;
            end else begin
              state_q    <= RD_ISSUE;
              mem_en_q   <= 1'b1;
              mem_addr_q <= bus.cmd_addr;
            end
          end
        end
        WR: begin
          if (bus.wd_valid) begin
            mem_en_q    <= 1'b1;
            mem_wr_q    <= 1'b1;
            mem_addr_q  <= addr_q;
            mem_wdata_q <= bus.wd_data;
            addr_q      <= addr_inc;
            if (beats_q == '0) begin
              state_q <= IDLE;
            end else begin
              beats_q <= beats_q - ONE;
            end
          end
        end
        RD_ISSUE: begin
          state_q <= RD_CAPT;
        end
        RD_CAPT: begin
          rsp_data_q  <= bus.mem_rdata;
          rsp_last_q  <= (beats_q == '0);
          rsp_valid_q <= 1'b1;
          state_q     <= RSP;
        end
        RSP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (beats_q == '0) begin
              state_q <= IDLE;
            end else begin
              beats_q    <= beats_q - ONE;
              addr_q     <= addr_inc;
              mem_en_q   <= 1'b1;
              mem_addr_q <= addr_inc;
              state_q    <= RD_ISSUE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_access_ctrl.sv
// Scoreboard bench for ram_access_ctrl: stimulus queues expected RAM writes and read
// responses; a negedge monitor pops and compares them and checks timing rules.
module tb_ram_access_ctrl;
  localparam int AW = 3;
  localparam int DW = 8;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wexp_t;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          last;
  } rexp_t;

  typedef logic [DW-1:0] beats_t [8];

  logic clk;
  logic rst;

  ram_access_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  ram_access_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural single-port RAM: registered read, output forced to 0 when en is low
  logic [DW-1:0] ram [8];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_wr) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
    end else begin
      bus.mem_rdata <= '0;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_tests = 0;
  int     n_fail  = 0;
  wexp_t  exp_w[$];
  rexp_t  exp_r[$];
  logic [DW-1:0] model [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pops plus latency, stall-stability and strobe-timing rules
  initial begin : monitor
    int            cyc;
    int            pend_cyc;
    logic          pend;
    logic          prev_stall;
    logic          prev_valid;
    logic          prev_wd_hs;
    logic          strobe;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    wexp_t         w;
    rexp_t         r;
    cyc = 0; pend_cyc = 0; pend = 0; prev_stall = 0; prev_valid = 0;
    prev_wd_hs = 0; prev_data = '0; prev_last = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        pend = 0; prev_stall = 0; prev_valid = 0; prev_wd_hs = 0;
      end else begin
        strobe = bus.mem_en && bus.mem_wr;
        chk("wr_strobe_timing", strobe, prev_wd_hs);
        if (strobe) begin
          chk("wr_expected", exp_w.size() != 0, 1);
          if (exp_w.size() != 0) begin
            w = exp_w.pop_front();
            chk("wr_addr", bus.mem_addr, w.a);
            chk("wr_data", bus.mem_wdata, w.d);
          end
        end
        if (prev_stall) begin
          chk("stall_valid", bus.rsp_valid, 1);
          chk("stall_data", bus.rsp_data, prev_data);
          chk("stall_last", bus.rsp_last, prev_last);
          chk("stall_mem_en", bus.mem_en, 0);
        end
        if (bus.rsp_valid && !prev_valid && pend) begin
          chk("rd_latency", cyc - pend_cyc, 3);
          pend = 0;
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
          chk("rsp_expected", exp_r.size() != 0, 1);
          if (exp_r.size() != 0) begin
            r = exp_r.pop_front();
            chk("rsp_data", bus.rsp_data, r.d);
            chk("rsp_last", bus.rsp_last, r.last);
          end
          if (!bus.rsp_last) begin
            pend = 1; pend_cyc = cyc;
          end
        end
        if (bus.cmd_valid && bus.cmd_ready && !bus.cmd_wr) begin
          pend = 1; pend_cyc = cyc;
        end
        prev_stall = bus.rsp_valid && !bus.rsp_ready;
        prev_valid = bus.rsp_valid;
        prev_data  = bus.rsp_data;
        prev_last  = bus.rsp_last;
        prev_wd_hs = bus.wd_valid && bus.wd_ready;
      end
    end
  end

  task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [AW-1:0] l);
    int unsigned t;
    logic        acc;
    t = 0; acc = 0;
    bus.cmd_wr = wr; bus.cmd_addr = a; bus.cmd_len = l; bus.cmd_valid = 1'b1;
    while (!acc && t < 100) begin
      @(posedge clk);
      acc = bus.cmd_ready;
      t++;
    end
    #1 bus.cmd_valid = 1'b0;
    chk("cmd_accept", acc, 1);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [AW-1:0] l,
                          input beats_t d, input int unsigned gap);
    int unsigned t;
    logic        acc;
    logic [AW-1:0] wa;
    send_cmd(1'b1, a, l);
    for (int unsigned i = 0; i <= l; i++) begin
      wa = a + AW'(i);
      model[wa] = d[i];
      exp_w.push_back('{a: wa, d: d[i]});
      bus.wd_data = d[i]; bus.wd_valid = 1'b1;
      t = 0; acc = 0;
      while (!acc && t < 100) begin
        @(posedge clk);
        acc = bus.wd_ready;
        t++;
      end
      #1 bus.wd_valid = 1'b0;
      chk("wd_accept", acc, 1);
      if (i != l && gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic push_reads(input logic [AW-1:0] a, input logic [AW-1:0] l);
    logic [AW-1:0] ra;
    for (int unsigned i = 0; i <= l; i++) begin
      ra = a + AW'(i);
      exp_r.push_back('{d: model[ra], last: (i == l)});
    end
  endtask

  task automatic wait_idle();
    int unsigned t;
    logic        ok;
    t = 0; ok = 0;
    while (!ok && t < 200) begin
      @(posedge clk);
      ok = !bus.busy && (exp_r.size() == 0);
      t++;
    end
    #1;
    chk("idle_reached", ok, 1);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] l, input int unsigned stall);
    int unsigned t;
    push_reads(a, l);
    bus.rsp_ready = (stall == 0);
    send_cmd(1'b0, a, l);
    if (stall > 0) begin
      t = 0;
      while (!bus.rsp_valid && t < 100) begin
        @(posedge clk);
        t++;
      end
      chk("stall_rsp_seen", bus.rsp_valid, 1);
      repeat (stall) @(posedge clk);
      #1 bus.rsp_ready = 1'b1;
    end
    wait_idle();
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_mem_en"},    bus.mem_en, 0);
    chk({tag, "_mem_wr"},    bus.mem_wr, 0);
    chk({tag, "_mem_addr"},  bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_data"},  bus.rsp_data, 0);
    chk({tag, "_rsp_last"},  bus.rsp_last, 0);
    chk({tag, "_busy"},      bus.busy, 0);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int unsigned t;
    int          cnt;
    for (int i = 0; i < 8; i++) model[i] = '0;
    rst = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b0; bus.cmd_addr = 3'd3; bus.cmd_len = '0;
    bus.wd_valid = 1'b0; bus.wd_data = '0; bus.rsp_ready = 1'b1;

    // Reset with a read command offered throughout
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_cleared("reset");
    @(posedge clk);
    #1 rst = 1'b0; bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("post_reset_cmd_ready", bus.cmd_ready, 1);
    chk("post_reset_busy", bus.busy, 0);
    @(negedge clk);
    chk("post_reset_not_accepted", bus.busy, 0);
    @(posedge clk); #1;

    // Single writes, then read straight back in the first IDLE cycle
    do_write(3'd5, 3'd0, '{8'h5A, 0, 0, 0, 0, 0, 0, 0}, 0);
    wait_idle();
    do_write(3'd7, 3'd0, '{8'd19, 0, 0, 0, 0, 0, 0, 0}, 0);
    do_read(3'd7, 3'd0, 0);

    // Wrapping back-to-back burst write and read-back
    do_write(3'd6, 3'd3, '{8'd55, 8'd20, 8'd1, 8'd2, 0, 0, 0, 0}, 0);
    do_read(3'd6, 3'd3, 0);

    // Write burst with two idle cycles between beats
    do_write(3'd2, 3'd2, '{8'hA1, 8'hB2, 8'hC3, 0, 0, 0, 0, 0}, 2);
    wait_idle();

    // First beat held for several cycles by rsp_ready low
    do_read(3'd0, 3'd2, 5);

    // Full-length wrapping read covering every word
    do_read(3'd5, 3'd7, 0);

    // Reset after the second beat of a full-length read
    push_reads(3'd3, 3'd7);
    bus.rsp_ready = 1'b1;
    send_cmd(1'b0, 3'd3, 3'd7);
    cnt = 0; t = 0;
    while (cnt < 2 && t < 100) begin
      @(posedge clk);
      if (bus.rsp_valid && bus.rsp_ready) cnt++;
      t++;
    end
    #1 rst = 1'b1;
    exp_r.delete();
    chk("rst_mid_handshakes", cnt, 2);
    @(posedge clk);
    @(negedge clk);
    chk_cleared("rst_mid");
    @(posedge clk);
    #1 rst = 1'b0;
    do_read(3'd0, 3'd0, 0);

    repeat (3) @(posedge clk);
    chk("wr_queue_drained", exp_w.size(), 0);
    chk("rsp_queue_drained", exp_r.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
